// File: rtl/gray_pkg.sv
// Shared width defaults and Gray/binary conversion helpers for the Gray sequencing counter.
// Functions work on the widest supported word; narrower callers zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 4;
    localparam int GRAY_MAX_WIDTH     = 16;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended upper bits decode to zero, so truncating the result is exact.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary decoder used on the preload path.
module gray2bin_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out
);

    always_comb begin
        bin_out = WIDTH'(gray2bin(gray_word_t'(gray_in)));
    end

endmodule

// File: rtl/gray_seq_counter.sv
// Up/down counter producing a registered binary count and its Gray code on the same edge,
// with a Gray-coded preload and a one-cycle wrap pulse.
module gray_seq_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             wrap
);

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_d;
    logic             wrap_q;

    gray2bin_conv #(
        .WIDTH(WIDTH)
    ) u_load_dec (
        .gray_in(load_gray),
        .bin_out(load_bin)
    );

    // Load beats counting; a hold keeps the pair as-is and clears wrap.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            gray_d = load_gray;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + WIDTH'(1);
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - WIDTH'(1);
                wrap_d = ~|bin_q;
            end
            gray_d = WIDTH'(bin2gray(gray_word_t'(bin_d)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
